wb_cmd_master: RTL and testbench
================================

# wb_cmd_master

Wishbone B4 classic-cycle initiator: turns single register-access commands from an internal valid/ready command port into Wishbone bus cycles toward peripherals such as the PWM/timer slave. It returns read data and a termination status on a valid/ready response port. It handles ERR, bounded RTY retries with backoff, and a no-response timeout, so a hung slave never stalls the requester.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles with CYC/STB high and no ACK/ERR/RTY before abort (1..65535).
- MAX_RETRY, 3: RTY terminations re-issued before giving up (0..15).
- RETRY_GAP, 2: idle cycles with CYC low between a RTY and the re-issue (1..15).

Ports:
- wb_clk_i  in  1  clock; every signal is sampled and updated on its rising edge.
- wb_rst_ni  in  1  reset; synchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when both valid and ready are high.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data.
- cmd_sel  in  4  byte selects.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when both valid and ready are high.
- rsp_dat  out  32  read data; 0 for writes and for failed cycles.
- rsp_status  out  2  00 OK, 01 ERR, 10 RTY exhausted, 11 TIMEOUT.
- wb_cyc_o, wb_stb_o  out  1 each  bus cycle and strobe (always equal).
- wb_we_o  out  1  write enable.
- wb_adr_o  out  32  address.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  byte selects.
- wb_cti_o  out  3  constant 3'b000 (classic).
- wb_bte_o  out  2  constant 2'b00.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i, wb_rty_i  in  1 each  slave terminations.

## Operation
- States: IDLE, BUS, GAP, RESP.
- IDLE:
  - cmd_ready = 1. All other outputs are 0.
  - On handshake, latch we/adr/dat/sel into the wb_*_o registers, clear the retry and timeout counters, go to BUS.
- BUS:
  - wb_cyc_o = wb_stb_o = 1. Address, data, sel and we are held stable for the whole cycle.
  - Each edge samples the terminations with priority ERR > ACK > RTY.
  - ERR: status 01, go to RESP.
  - ACK: status 00; rsp_dat = wb_dat_i if read, 0 if write; go to RESP.
  - RTY with retry_cnt < MAX_RETRY: increment retry_cnt, load gap counter, go to GAP.
  - RTY with retry_cnt = MAX_RETRY: status 10, go to RESP.
  - No termination: increment the timeout counter. When it reaches TIMEOUT_CYCLES, status 11, go to RESP.
  - The timeout counter restarts at 0 on every entry to BUS.
- GAP:
  - CYC and STB are low; address and data registers are held.
  - After RETRY_GAP cycles, return to BUS.
- RESP:
  - rsp_valid = 1; rsp_dat and rsp_status are held stable.
  - On rsp_ready, go to IDLE.
  - cmd_ready = 0 in BUS, GAP and RESP, so there is never more than one command outstanding.
- Terminations arriving while CYC is low (GAP, RESP, IDLE) are ignored.
- Reset (wb_rst_ni = 0 at an edge) forces IDLE from any state:
  - All outputs go to 0 on that edge, including rsp_valid, rsp_dat, rsp_status and all wb_*_o.
  - An in-flight bus cycle is dropped with no response.
  - cmd_ready goes to 1 on the first edge after reset is released.

## Timing
- All outputs are registered except cmd_ready, which is decoded from the IDLE state.
- Minimum latency:
  - Handshake at edge 0.
  - CYC/STB high from edge 0 to edge 1.
  - ACK sampled at edge 1.
  - CYC low and rsp_valid high after edge 1, so a 1-cycle bus phase.
- Each sample with no termination adds one cycle.
- A back-to-back command can be accepted in the cycle after the rsp handshake; CYC is always low for at least 1 cycle between commands.
- A timeout holds CYC high for exactly TIMEOUT_CYCLES cycles.
- Each retry adds RETRY_GAP cycles with CYC low.

## Test plan
- **Read, immediate ACK:** read adr 0x0000_0004, slave ACKs on the first STB cycle with dat 0xDEAD_BEEF -> CYC high for exactly 1 cycle; rsp_dat = 0xDEAD_BEEF, status 00 on the next cycle.
- **Write, 3 wait states:** write 0x0000_00FF to adr 0x0C with sel 4'hF, ACK on the 4th cycle -> wb_adr_o, wb_dat_o, wb_sel_o and wb_we_o stable for 4 cycles; rsp_dat = 0, status 00.
- **ERR with simultaneous ACK:** ERR and ACK asserted together on the 2nd cycle -> status 01, rsp_dat = 0.
- **Retry then success:** MAX_RETRY = 3, RETRY_GAP = 2; slave gives RTY twice, then ACK -> three CYC assertions, each separated by 2 low cycles; status 00.
- **Retry exhausted:** the same slave gives RTY four times -> status 10.
- **Timeout and reset:** TIMEOUT_CYCLES = 8 with a silent slave -> CYC high for 8 cycles, then status 11 and cmd_ready low until rsp_ready. Separately, assert reset during the 3rd BUS cycle -> CYC and all outputs are 0 on the next edge, no rsp_valid, and cmd_ready = 1 one edge after reset is released.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Wishbone B4 classic-cycle initiator. Accepts one register-access command
// at a time, runs it as a bus cycle with ERR/RTY/timeout handling and returns
// read data plus a termination status on the response port.
module wb_cmd_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned MAX_RETRY      = 3,
   parameter int unsigned RETRY_GAP      = 2
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic [1:0]  rsp_status,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic [2:0]  wb_cti_o,
   output logic [1:0]  wb_bte_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   input  logic        wb_rty_i
);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_GAP, S_RESP} state_e;

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_ERR = 2'b01;
   localparam logic [1:0] ST_RTY = 2'b10;
   localparam logic [1:0] ST_TMO = 2'b11;

   state_e      state_q, state_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [3:0]  sel_q, sel_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_dat_q, rsp_dat_d;
   logic [1:0]  rsp_status_q, rsp_status_d;
   logic [3:0]  retry_q, retry_d;
   logic [15:0] tmo_q, tmo_d;
   logic [3:0]  gap_q, gap_d;
   // Keeps cmd_ready low while reset is asserted; it rises one edge after release.
   logic        rdy_en_q;

   assign cmd_ready  = (state_q == S_IDLE) && rdy_en_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_dat    = rsp_dat_q;
   assign rsp_status = rsp_status_q;
   assign wb_cyc_o   = cyc_q;
   assign wb_stb_o   = cyc_q;
   assign wb_we_o    = we_q;
   assign wb_adr_o   = adr_q;
   assign wb_dat_o   = dat_q;
   assign wb_sel_o   = sel_q;
   assign wb_cti_o   = 3'b000;
   assign wb_bte_o   = 2'b00;

   // Next-state and registered-output decode for the bus sequencer.
   always_comb begin
      state_d      = state_q;
      cyc_d        = cyc_q;
      we_d         = we_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      sel_d        = sel_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_dat_d    = rsp_dat_q;
      rsp_status_d = rsp_status_q;
      retry_d      = retry_q;
      tmo_d        = tmo_q;
      gap_d        = gap_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_d = S_BUS;
               cyc_d   = 1'b1;
               we_d    = cmd_we;
               adr_d   = cmd_adr;
               dat_d   = cmd_dat;
               sel_d   = cmd_sel;
               retry_d = '0;
               tmo_d   = '0;
            end
         end
         S_BUS: begin
            if (wb_err_i) begin
               state_d      = S_RESP;
               cyc_d        = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_dat_d    = '0;
               rsp_status_d = ST_ERR;
            end else if (wb_ack_i) begin
               state_d      = S_RESP;
               cyc_d        = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_dat_d    = we_q ? '0 : wb_dat_i;
               rsp_status_d = ST_OK;
            end else if (wb_rty_i) begin
               if (retry_q < 4'(MAX_RETRY)) begin
                  state_d = S_GAP;
                  cyc_d   = 1'b0;
                  retry_d = retry_q + 4'd1;
                  gap_d   = 4'(RETRY_GAP - 1);
               end else begin
                  state_d      = S_RESP;
                  cyc_d        = 1'b0;
                  rsp_valid_d  = 1'b1;
                  rsp_dat_d    = '0;
                  rsp_status_d = ST_RTY;
               end
            end else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
               state_d      = S_RESP;
               cyc_d        = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_dat_d    = '0;
               rsp_status_d = ST_TMO;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               state_d = S_BUS;
               cyc_d   = 1'b1;
               tmo_d   = '0;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d      = S_IDLE;
               rsp_valid_d  = 1'b0;
               rsp_dat_d    = '0;
               rsp_status_d = '0;
               we_d         = 1'b0;
               adr_d        = '0;
               dat_d        = '0;
               sel_d        = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q      <= S_IDLE;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         adr_q        <= '0;
         dat_q        <= '0;
         sel_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_dat_q    <= '0;
         rsp_status_q <= '0;
         retry_q      <= '0;
         tmo_q        <= '0;
         gap_q        <= '0;
         rdy_en_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         we_q         <= we_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         sel_q        <= sel_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_dat_q    <= rsp_dat_d;
         rsp_status_q <= rsp_status_d;
         retry_q      <= retry_d;
         tmo_q        <= tmo_d;
         gap_q        <= gap_d;
         rdy_en_q     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed scenarios followed by
// randomized transactions, each scored against a transaction-level model.
module tb_wb_cmd_master;

   localparam int unsigned TMO = 8;
   localparam int unsigned MR  = 3;
   localparam int unsigned RG  = 2;

   localparam int unsigned T_ACK    = 0;
   localparam int unsigned T_ERR    = 1;
   localparam int unsigned T_ERRACK = 2;
   localparam int unsigned T_RTY    = 3;
   localparam int unsigned T_NONE   = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr, cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_dat;
   logic [1:0]  rsp_status;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic [2:0]  wb_cti_o;
   logic [1:0]  wb_bte_o;
   logic        wb_ack_i, wb_err_i, wb_rty_i;

   int unsigned vectors = 0;
   int unsigned fails   = 0;

   // Slave behaviour for the current transaction: per attempt, wait states
   // before the termination, the termination kind and the read data.
   int unsigned plan_n;
   int unsigned plan_t [8];
   int unsigned plan_w [8];
   logic [31:0] plan_d [8];

   always #5 clk = ~clk;

   wb_cmd_master #(
      .TIMEOUT_CYCLES(TMO),
      .MAX_RETRY     (MR),
      .RETRY_GAP     (RG)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_adr   (cmd_adr),
      .cmd_dat   (cmd_dat),
      .cmd_sel   (cmd_sel),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_dat   (rsp_dat),
      .rsp_status(rsp_status),
      .wb_cyc_o  (wb_cyc_o),
      .wb_stb_o  (wb_stb_o),
      .wb_we_o   (wb_we_o),
      .wb_adr_o  (wb_adr_o),
      .wb_dat_o  (wb_dat_o),
      .wb_sel_o  (wb_sel_o),
      .wb_cti_o  (wb_cti_o),
      .wb_bte_o  (wb_bte_o),
      .wb_dat_i  (wb_dat_i),
      .wb_ack_i  (wb_ack_i),
      .wb_err_i  (wb_err_i),
      .wb_rty_i  (wb_rty_i)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic plan_clear;
      plan_n = 0;
   endtask

   task automatic plan_add(input int unsigned t, input int unsigned w, input logic [31:0] d);
      plan_t[plan_n] = t;
      plan_w[plan_n] = w;
      plan_d[plan_n] = d;
      plan_n++;
   endtask

   task automatic terms_off;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_rty_i = 1'b0;
   endtask

   task automatic terms_rand;
      {wb_ack_i, wb_err_i, wb_rty_i} = 3'($urandom);
      wb_dat_i = $urandom;
   endtask

   // Called one step after an edge with the DUT idle; returns idle again.
   task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
      int unsigned retries = 0;
      int unsigned exp_att = 0;
      int unsigned exp_run [8];
      logic [1:0]  exp_st  = 2'b00;
      logic [31:0] exp_dat = '0;
      int unsigned a = 0, c = 0, run = 0, gaprun = 0;
      logic        prev_cyc = 1'b0;
      bit          done = 1'b0;

      // Reference outcome from the attempt plan.
      for (int i = 0; i < int'(plan_n); i++) begin
         exp_att = i + 1;
         if (plan_t[i] == T_NONE || plan_w[i] >= TMO) begin
            exp_run[i] = TMO; exp_st = 2'b11; exp_dat = '0; break;
         end
         exp_run[i] = plan_w[i] + 1;
         if (plan_t[i] == T_ERR || plan_t[i] == T_ERRACK) begin
            exp_st = 2'b01; exp_dat = '0; break;
         end
         if (plan_t[i] == T_ACK) begin
            exp_st = 2'b00; exp_dat = we ? 32'h0 : plan_d[i]; break;
         end
         if (retries < MR) retries++;
         else begin
            exp_st = 2'b10; exp_dat = '0; break;
         end
      end

      chk("cmd_ready_idle", 32'(cmd_ready), 32'h1);
      cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
      terms_off();
      tick();
      cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);

      for (int n = 0; n < 400 && !done; n++) begin
         if (prev_cyc && !wb_cyc_o) begin
            chk("cyc_run_len", run, exp_run[a]);
            chk("rsp_at_cyc_fall", 32'(rsp_valid), 32'(a + 1 == exp_att));
            a++; c = 0; run = 0; gaprun = 0;
         end
         if (!prev_cyc && wb_cyc_o && a > 0) chk("retry_gap_len", gaprun, RG);
         if (rsp_valid) begin
            done = 1'b1;
         end else if (wb_cyc_o) begin
            chk("stb_eq_cyc", 32'(wb_stb_o), 32'h1);
            chk("bus_adr", wb_adr_o, adr);
            chk("bus_dat", wb_dat_o, dat);
            chk("bus_sel", 32'(wb_sel_o), 32'(sel));
            chk("bus_we", 32'(wb_we_o), 32'(we));
            chk("bus_cti_bte", 32'({wb_cti_o, wb_bte_o}), 32'h0);
            chk("bus_cmd_ready", 32'(cmd_ready), 32'h0);
            terms_off();
            wb_dat_i = $urandom;
            if (a < plan_n && c == plan_w[a]) begin
               case (plan_t[a])
                  T_ACK:    begin wb_ack_i = 1'b1; wb_dat_i = plan_d[a]; end
                  T_ERR:    wb_err_i = 1'b1;
                  T_ERRACK: begin wb_err_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = plan_d[a]; end
                  T_RTY:    wb_rty_i = 1'b1;
                  default:  ;
               endcase
            end
            c++; run++;
         end else begin
            gaprun++;
            chk("gap_cmd_ready", 32'(cmd_ready), 32'h0);
            terms_rand();
         end
         prev_cyc = wb_cyc_o;
         if (!done) tick();
      end

      chk("rsp_arrived", 32'(rsp_valid), 32'h1);
      chk("attempts", a, exp_att);
      chk("rsp_status", 32'(rsp_status), 32'(exp_st));
      chk("rsp_dat", rsp_dat, exp_dat);

      // Hold off the consumer a little while the slave drives noise.
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
         terms_rand();
         tick();
         chk("rsp_hold_valid", 32'(rsp_valid), 32'h1);
         chk("rsp_hold_status", 32'(rsp_status), 32'(exp_st));
         chk("rsp_hold_dat", rsp_dat, exp_dat);
         chk("rsp_cyc_low", 32'(wb_cyc_o), 32'h0);
         chk("rsp_cmd_ready", 32'(cmd_ready), 32'h0);
      end
      terms_rand();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      terms_off();
      chk("post_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("post_cmd_ready", 32'(cmd_ready), 32'h1);
      chk("post_idle_outs", {wb_cyc_o, wb_we_o, wb_sel_o, rsp_status} == '0 ? 32'h0 : 32'h1, 32'h0);
      chk("post_idle_adr", wb_adr_o | wb_dat_o | rsp_dat, 32'h0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, rsp_valid, rsp_status, cmd_ready}), 32'h0);
      chk(tag, wb_adr_o | wb_dat_o | rsp_dat, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
      rsp_ready = 1'b0; wb_dat_i = '0;
      terms_off();
      tick(); tick(); tick();
      chk_all_zero("reset_outputs");
      rst_n = 1'b1;
      tick();
      chk("reset_release_ready", 32'(cmd_ready), 32'h1);

      // Read, immediate ACK.
      plan_clear(); plan_add(T_ACK, 0, 32'hDEAD_BEEF);
      run_txn(1'b0, 32'h0000_0004, 32'h1234_5678, 4'hF);
      // Write, 3 wait states.
      plan_clear(); plan_add(T_ACK, 3, 32'hCAFE_F00D);
      run_txn(1'b1, 32'h0000_000C, 32'h0000_00FF, 4'hF);
      // ERR together with ACK on the 2nd cycle.
      plan_clear(); plan_add(T_ERRACK, 1, 32'h5555_AAAA);
      run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h3);
      // Two retries then success.
      plan_clear(); plan_add(T_RTY, 0, 0); plan_add(T_RTY, 1, 0); plan_add(T_ACK, 0, 32'h0BAD_F00D);
      run_txn(1'b0, 32'h0000_0020, 32'h0, 4'hF);
      // Retries exhausted.
      plan_clear(); for (int i = 0; i < 4; i++) plan_add(T_RTY, 0, 0);
      run_txn(1'b1, 32'h0000_0024, 32'h1111_2222, 4'h1);
      // Silent slave -> timeout.
      plan_clear(); plan_add(T_NONE, 0, 0);
      run_txn(1'b0, 32'h0000_0028, 32'h0, 4'hF);
      // ACK on the last cycle before timeout, then one cycle too late.
      plan_clear(); plan_add(T_ACK, TMO - 1, 32'h7777_0001);
      run_txn(1'b0, 32'h0000_002C, 32'h0, 4'hF);
      plan_clear(); plan_add(T_ACK, TMO, 32'h7777_0002);
      run_txn(1'b0, 32'h0000_0030, 32'h0, 4'hF);

      // Reset during the 3rd BUS cycle drops the cycle with no response.
      terms_off();
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h40; cmd_dat = '0; cmd_sel = 4'hF;
      tick();
      cmd_valid = 1'b0;
      chk("rst_bus_cyc1", 32'(wb_cyc_o), 32'h1);
      tick(); tick();
      chk("rst_bus_cyc3", 32'(wb_cyc_o), 32'h1);
      rst_n = 1'b0;
      tick();
      chk_all_zero("reset_mid_bus");
      rst_n = 1'b1;
      tick();
      chk("rst_rel_ready", 32'(cmd_ready), 32'h1);
      chk("rst_rel_no_rsp", 32'({rsp_valid, wb_cyc_o}), 32'h0);

      // Randomized transactions.
      for (int t = 0; t < 50; t++) begin
         int unsigned nr;
         int unsigned r;
         plan_clear();
         nr = $urandom_range(0, 4);
         for (int i = 0; i < int'(nr); i++) plan_add(T_RTY, $urandom_range(0, 3), $urandom);
         if (nr <= MR) begin
            r = $urandom_range(0, 9);
            plan_add(r < 5 ? T_ACK : r < 7 ? T_ERR : r < 8 ? T_ERRACK : T_NONE,
                     $urandom_range(0, 9), $urandom);
         end
         for (int k = $urandom_range(0, 2); k > 0; k--) begin
            terms_rand();
            tick();
            chk("idle_cyc_low", 32'(wb_cyc_o), 32'h0);
         end
         run_txn(1'($urandom), $urandom, $urandom, 4'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
